fsm_rr_arb: RTL and testbench

- Parametrised successor to the four-agent request/grant FSM arbiter: NUM_REQ agents, round-robin fairness, bounded grant tenure.
- Sits between N requesting agents and one shared resource; issues one-hot registered grants.
- Adds fairness pointer, hold-timeout preemption and encoded grant index, none of which exist in the fixed-priority 4-agent generation.

---
 rtl/fsm_rr_arb_pkg.sv | 22 ++
 rtl/fsm_rr_arb_if.sv | 18 +
 rtl/rr_pick.sv | 36 +++
 rtl/fsm_rr_arb.sv | 115 +++++++++++
 tb/tb_fsm_rr_arb.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/fsm_rr_arb_pkg.sv
// Shared types and helpers for the round-robin grant arbiter.
package fsm_rr_arb_pkg;

  localparam int unsigned HOLD_W = 8;

  // Sparse encoding so a corrupted state register is recognisable.
  typedef enum logic [1:0] {
    IDLE  = 2'b01,
    GRANT = 2'b10
  } state_t;

  // Index of the set bit in a one-hot vector; supports up to 32 agents.
  function automatic logic [4:0] oh_to_idx(input logic [31:0] oh);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) idx = idx | 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/fsm_rr_arb_if.sv
// Request/grant bundle between the agents (master) and the arbiter (slave).
interface fsm_rr_arb_if
  import fsm_rr_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
);
  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic               gnt_valid;
  logic [IDX_W-1:0]   gnt_idx;
  logic [HOLD_W-1:0]  hold_cnt;

  modport master (output req, input gnt, gnt_valid, gnt_idx, hold_cnt);
  modport slave  (input req, output gnt, gnt_valid, gnt_idx, hold_cnt);

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_pick
  import fsm_rr_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] win_oh,
  output logic [IDX_W-1:0]   win_idx,
  output logic               any_req_c
);

  logic        found;
  int unsigned j;

  // Scan NUM_REQ positions starting at ptr, modulo NUM_REQ.
  always_comb begin
    win_oh = '0;
    found  = 1'b0;
    j      = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      j = 32'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req[j]) begin
        win_oh[j] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  assign win_idx   = IDX_W'(oh_to_idx(32'(win_oh)));
  assign any_req_c = |req;

endmodule

// File: rtl/fsm_rr_arb.sv
// Round-robin request/grant arbiter with bounded tenure and encoded grant index.
// Optional owner lock against timeout preemption: define FSM_RR_ARB_LOCK_EN.
module fsm_rr_arb
  import fsm_rr_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic         clock,
  input  logic         reset,
`ifdef FSM_RR_ARB_LOCK_EN
  input  logic         lock,
`endif
  fsm_rr_arb_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               valid_q, valid_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;

  logic [NUM_REQ-1:0] win_oh;
  logic [IDX_W-1:0]   win_idx;
  logic               any_req;
  logic               own_req;
  logic               other_req;
  logic               timeout;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req       (bus.req),
    .ptr       (ptr_q),
    .win_oh    (win_oh),
    .win_idx   (win_idx),
    .any_req_c (any_req)
  );

  assign own_req   = |(bus.req & gnt_q);
  assign other_req = |(bus.req & ~gnt_q);

`ifdef FSM_RR_ARB_LOCK_EN
  assign timeout = (hold_q >= HOLD_W'(MAX_HOLD)) && !lock;
`else
  assign timeout = (hold_q >= HOLD_W'(MAX_HOLD));
`endif

  // Next-state and next-output decode.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;

    unique case (state_q)
      IDLE, GRANT: begin
        if (state_q == GRANT && own_req && (!timeout || !other_req)) begin
          hold_d = (hold_q == '1) ? hold_q : hold_q + HOLD_W'(1);
        end else if (any_req) begin
          // New tenure: idle start, handover or preemption all land here.
          state_d = GRANT;
          gnt_d   = win_oh;
          valid_d = 1'b1;
          idx_d   = win_idx;
          hold_d  = HOLD_W'(1);
          ptr_d   = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
        end else begin
          state_d = IDLE;
          gnt_d   = '0;
          valid_d = 1'b0;
          idx_d   = '0;
          hold_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        valid_d = 1'b0;
        idx_d   = '0;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = valid_q;
  assign bus.gnt_idx   = idx_q;
  assign bus.hold_cnt  = hold_q;

endmodule

// File: tb/tb_fsm_rr_arb.sv
// Directed bench for fsm_rr_arb (4 agents, MAX_HOLD=8) with an expectation queue.
module tb_fsm_rr_arb;

  typedef struct {
    logic [3:0] gnt;
    logic [7:0] hold;
    string      tag;
  } exp_t;

  logic clock;
  logic reset;
`ifdef FSM_RR_ARB_LOCK_EN
  logic lock;
`endif

  int errors;
  int checks;
  exp_t q[$];

  fsm_rr_arb_if #(.NUM_REQ(4)) bus ();

  fsm_rr_arb #(
    .NUM_REQ  (4),
    .MAX_HOLD (8)
  ) dut (
    .clock (clock),
    .reset (reset),
`ifdef FSM_RR_ARB_LOCK_EN
    .lock  (lock),
`endif
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Pop the oldest expectation and compare it with the current outputs.
  task automatic check_out();
    exp_t       e;
    logic [1:0] ei;
    checks++;
    assert (q.size() != 0) else begin
      errors++;
      $error("FAIL queue: got empty expected entry");
    end
    if (q.size() != 0) begin
      e  = q.pop_front();
      ei = 2'd0;
      for (int i = 0; i < 4; i++) if (e.gnt[i]) ei = 2'(i);
      cmp({e.tag, " gnt"},   32'(bus.gnt),       32'(e.gnt));
      cmp({e.tag, " valid"}, 32'(bus.gnt_valid), 32'(|e.gnt));
      cmp({e.tag, " idx"},   32'(bus.gnt_idx),   32'(ei));
      cmp({e.tag, " hold"},  32'(bus.hold_cnt),  32'(e.hold));
    end
  endtask

  // Drive req for one cycle; expected outputs are those after the next edge.
  task automatic step(input logic [3:0] r, input logic [3:0] eg, input logic [7:0] eh, input string tag);
    exp_t e;
    bus.req = r;
    e.gnt = eg; e.hold = eh; e.tag = tag;
    q.push_back(e);
    @(posedge clock); #1;
    check_out();
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    reset   = 1'b0;
    bus.req = 4'b0000;
`ifdef FSM_RR_ARB_LOCK_EN
    lock    = 1'b0;
`endif
    repeat (3) @(posedge clock);
    #1;
    cmp("rst gnt",   32'(bus.gnt),       32'd0);
    cmp("rst valid", 32'(bus.gnt_valid), 32'd0);
    cmp("rst idx",   32'(bus.gnt_idx),   32'd0);
    cmp("rst hold",  32'(bus.hold_cnt),  32'd0);
    reset = 1'b1;
    step(4'b0000, 4'b0000, 8'd0, "idle");

    // Single requesters one at a time, idle gap between them.
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 5; k++) step(4'(1 << i), 4'(1 << i), 8'(k + 1), "single");
      step(4'b0000, 4'b0000, 8'd0, "single rel");
      step(4'b0000, 4'b0000, 8'd0, "single idle");
    end

    // All requesting: 8-cycle tenures rotating 0,1,2,3,0 with no gaps.
    for (int k = 0; k < 40; k++) step(4'b1111, 4'(1 << ((k / 8) % 4)), 8'((k % 8) + 1), "rotate");
    step(4'b0000, 4'b0000, 8'd0, "rotate rel");

    // Pointer now 1: agent 1 owns, drops with 0 and 3 pending -> 3, then pointer 0 -> 0.
    step(4'b0010, 4'b0010, 8'd1, "hand own1");
    step(4'b1011, 4'b0010, 8'd2, "hand keep");
    step(4'b1001, 4'b1000, 8'd1, "hand to3");
    step(4'b1001, 4'b1000, 8'd2, "hand keep3");
    step(4'b0001, 4'b0001, 8'd1, "hand wrap0");
    step(4'b0000, 4'b0000, 8'd0, "hand rel");

    // Sole requester for 300 cycles: never preempted, counter saturates.
    for (int k = 0; k < 300; k++) step(4'b0001, 4'b0001, 8'((k + 1 > 255) ? 255 : k + 1), "sat");
    step(4'b0000, 4'b0000, 8'd0, "sat rel");

`ifdef FSM_RR_ARB_LOCK_EN
    // Move pointer to 0, then hold agent 0 under lock past MAX_HOLD.
    step(4'b1000, 4'b1000, 8'd1, "lock prep");
    step(4'b0000, 4'b0000, 8'd0, "lock prep rel");
    lock = 1'b1;
    for (int k = 0; k < 12; k++) step(4'b0011, 4'b0001, 8'(k + 1), "lock hold");
    lock = 1'b0;
    step(4'b0011, 4'b0010, 8'd1, "lock drop");
    step(4'b0000, 4'b0000, 8'd0, "lock rel");
`endif

    // Reset mid-tenure clears outputs without waiting for an edge.
    step(4'b0100, 4'b0100, 8'd1, "mid own2");
    step(4'b0100, 4'b0100, 8'd2, "mid keep2");
    #2;
    reset = 1'b0;
    #1;
    cmp("mid rst gnt",   32'(bus.gnt),       32'd0);
    cmp("mid rst valid", 32'(bus.gnt_valid), 32'd0);
    cmp("mid rst idx",   32'(bus.gnt_idx),   32'd0);
    cmp("mid rst hold",  32'(bus.hold_cnt),  32'd0);
    bus.req = 4'b0010;
    @(posedge clock); #1;
    cmp("in rst gnt", 32'(bus.gnt), 32'd0);
    #2;
    reset = 1'b1;
    @(posedge clock); #1;
    step(4'b0010, 4'b0010, 8'd2, "post rst keep");
    step(4'b0000, 4'b0000, 8'd0, "post rst rel");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // First edge after release must grant agent 1 with a fresh tenure.
  initial begin
    wait (reset == 1'b0 && bus.req == 4'b0010);
    wait (reset == 1'b1);
    @(posedge clock); #1;
    cmp("post rst gnt",  32'(bus.gnt),      32'b0010);
    cmp("post rst hold", 32'(bus.hold_cnt), 32'd1);
  end

endmodule
